// File: rtl/decade_pkg.sv
// Shared 2-of-5 decade code constants used by the decade counter chain.
// Bit order within a code is {a,b,c,d,e}, with a as the MSB.
package decade_pkg;

  localparam int CODE_W     = 5;
  localparam int DIGITS_MAX = 8;

  localparam logic [CODE_W-1:0] CODE_0 = 5'b00011;
  localparam logic [CODE_W-1:0] CODE_1 = 5'b10010;
  localparam logic [CODE_W-1:0] CODE_2 = 5'b10001;
  localparam logic [CODE_W-1:0] CODE_3 = 5'b01001;
  localparam logic [CODE_W-1:0] CODE_4 = 5'b11000;
  localparam logic [CODE_W-1:0] CODE_5 = 5'b10100;
  localparam logic [CODE_W-1:0] CODE_6 = 5'b01100;
  localparam logic [CODE_W-1:0] CODE_7 = 5'b01010;
  localparam logic [CODE_W-1:0] CODE_8 = 5'b00110;
  localparam logic [CODE_W-1:0] CODE_9 = 5'b00101;

endpackage

// File: rtl/decade_step.sv
// Per-digit combinational step logic: successor/predecessor code, validity,
// and the is-9 / is-0 terms that feed the chain's carry and borrow.
module decade_step
  import decade_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] next_up,
  output logic [CODE_W-1:0] next_down,
  output logic              valid,
  output logic              is9,
  output logic              is0
);

  // Any code without exactly two 1 bits falls to the default arm, so an
  // invalid digit steps to 0 in either direction.
  always_comb begin
    valid     = 1'b1;
    next_up   = CODE_0;
    next_down = CODE_0;
    case (code)
      CODE_0: begin next_up = CODE_1; next_down = CODE_9; end
      CODE_1: begin next_up = CODE_2; next_down = CODE_0; end
      CODE_2: begin next_up = CODE_3; next_down = CODE_1; end
      CODE_3: begin next_up = CODE_4; next_down = CODE_2; end
      CODE_4: begin next_up = CODE_5; next_down = CODE_3; end
      CODE_5: begin next_up = CODE_6; next_down = CODE_4; end
      CODE_6: begin next_up = CODE_7; next_down = CODE_5; end
      CODE_7: begin next_up = CODE_8; next_down = CODE_6; end
      CODE_8: begin next_up = CODE_9; next_down = CODE_7; end
      CODE_9: begin next_up = CODE_0; next_down = CODE_8; end
      default: valid = 1'b0;
    endcase
  end

  assign is9 = (code == CODE_9);
  assign is0 = (code == CODE_0);

endmodule

// File: rtl/decade_chain.sv
// Cascaded 2-of-5 decade counter with edge-triggered set0/set9/load/advance.
// Optional sticky invalid-code checker enabled by macro DECADE_CHAIN_CHECK_EN.
module decade_chain
  import decade_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int UPDOWN = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_set0,
  input  logic                     i_set9,
  input  logic                     i_load,
  input  logic [CODE_W*DIGITS-1:0] i_load_value,
  input  logic                     i_advance,
  input  logic                     i_down,
  output logic [CODE_W*DIGITS-1:0] o_output,
  output logic                     o_wrap,
  output logic                     o_check
);

  localparam int OW = CODE_W * DIGITS;

  logic set0_q, set9_q, load_q, advance_q;
  logic set0_edge, set9_edge, load_edge, advance_edge;
  logic down;

  logic [DIGITS-1:0][CODE_W-1:0] nxt_up, nxt_down;
  logic [DIGITS-1:0]             dig_valid, dig_is9, dig_is0;

  logic [OW-1:0] step_value;
  logic          step_en;
  logic          step_wrap;

  assign set0_edge    = i_set0    & ~set0_q;
  assign set9_edge    = i_set9    & ~set9_q;
  assign load_edge    = i_load    & ~load_q;
  assign advance_edge = i_advance & ~advance_q;
  assign down         = (UPDOWN != 0) ? i_down : 1'b0;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    decade_step u_step (
      .code      (o_output[CODE_W*k +: CODE_W]),
      .next_up   (nxt_up[k]),
      .next_down (nxt_down[k]),
      .valid     (dig_valid[k]),
      .is9       (dig_is9[k]),
      .is0       (dig_is0[k])
    );
  end

  // Carry/borrow resolved in one pass: a digit moves only while every lower
  // digit was 9 (up) or 0 (down). An invalid digit is neither, so it stops
  // the chain and can never produce a wrap.
  always_comb begin
    step_value = o_output;
    step_en    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (step_en)
        step_value[CODE_W*k +: CODE_W] = down ? nxt_down[k] : nxt_up[k];
      step_en = step_en & (down ? dig_is0[k] : dig_is9[k]);
    end
    step_wrap = step_en;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      set0_q    <= 1'b0;
      set9_q    <= 1'b0;
      load_q    <= 1'b0;
      advance_q <= 1'b0;
      o_output  <= {DIGITS{CODE_0}};
      o_wrap    <= 1'b0;
    end else begin
      set0_q    <= i_set0;
      set9_q    <= i_set9;
      load_q    <= i_load;
      advance_q <= i_advance;
      o_wrap    <= 1'b0;
      if (set9_edge)
        o_output <= {DIGITS{CODE_9}};
      else if (set0_edge)
        o_output <= {DIGITS{CODE_0}};
      else if (load_edge)
        o_output <= i_load_value;
      else if (advance_edge) begin
        o_output <= step_value;
        o_wrap   <= step_wrap;
      end
    end
  end

`ifdef DECADE_CHAIN_CHECK_EN
  // Sticky: only an explicit set0/set9 edge (or reset) clears the flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_check <= 1'b0;
    else if (set0_edge || set9_edge)
      o_check <= 1'b0;
    else if (!(&dig_valid))
      o_check <= 1'b1;
  end
`else
  assign o_check = 1'b0;
`endif

endmodule

// File: tb/tb_decade_chain.sv
// Directed bench for decade_chain (DIGITS=2) with an expected-value queue
// drained by a negedge monitor.
module tb_decade_chain;

  localparam int DIGITS = 2;
  localparam int OW     = 5 * DIGITS;
  localparam int W      = OW + 2;

`ifdef DECADE_CHAIN_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  localparam logic [4:0] C0 = 5'b00011;
  localparam logic [4:0] C1 = 5'b10010;
  localparam logic [4:0] C2 = 5'b10001;
  localparam logic [4:0] C3 = 5'b01001;
  localparam logic [4:0] C4 = 5'b11000;
  localparam logic [4:0] C5 = 5'b10100;
  localparam logic [4:0] C6 = 5'b01100;
  localparam logic [4:0] C7 = 5'b01010;
  localparam logic [4:0] C8 = 5'b00110;
  localparam logic [4:0] C9 = 5'b00101;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          set0, set9, load, advance, down;
  logic [OW-1:0] load_value;
  logic [OW-1:0] dout;
  logic          wrap, check;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  decade_chain #(.DIGITS(DIGITS), .UPDOWN(1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_set0       (set0),
    .i_set9       (set9),
    .i_load       (load),
    .i_load_value (load_value),
    .i_advance    (advance),
    .i_down       (down),
    .o_output     (dout),
    .o_wrap       (wrap),
    .o_check      (check)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [4:0] code(input int n);
    case (n)
      0: code = C0; 1: code = C1; 2: code = C2; 3: code = C3; 4: code = C4;
      5: code = C5; 6: code = C6; 7: code = C7; 8: code = C8;
      default: code = C9;
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s9, input logic s0, input logic ld,
                       input logic adv, input logic dn);
    set9 = s9; set0 = s0; load = ld; advance = adv; down = dn;
    tick();
    set9 = 1'b0; set0 = 1'b0; load = 1'b0; advance = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [OW-1:0] o,
                            input logic w, input logic c);
    exp_q.push_back({o, w, c});
    name_q.push_back(name);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    string        n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if ({dout, wrap, check} !== e) begin
        errors++;
        $display("FAIL %s: got out=%b wrap=%b check=%b, expected out=%b wrap=%b check=%b",
                 n, dout, wrap, check, e[W-1:2], e[1], e[0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; set0 = 1'b0; set9 = 1'b0; load = 1'b0;
    advance = 1'b0; down = 1'b0; load_value = '0;
    repeat (2) tick();
    expect_out("reset_state", {C0, C0}, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // ten up steps from zero
    for (int i = 1; i <= 10; i++) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_out("count_up", {code(i / 10), code(i % 10)}, 1'b0, 1'b0);
      tick();
      expect_out("count_up_hold", {code(i / 10), code(i % 10)}, 1'b0, 1'b0);
    end

    // set9 then wrap upward
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("set9", {C9, C9}, 1'b0, 1'b0);
    tick();
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("wrap_up", {C0, C0}, 1'b1, 1'b0);
    tick();
    expect_out("wrap_up_one_clk", {C0, C0}, 1'b0, 1'b0);

    // set9 beats set0; held advance makes exactly one step
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("set9_over_set0", {C9, C9}, 1'b0, 1'b0);
    tick();
    advance = 1'b1; down = 1'b0;
    tick();
    expect_out("held_adv_first", {C0, C0}, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++) begin
      tick();
      expect_out("held_adv_hold", {C0, C0}, 1'b0, 1'b0);
    end
    advance = 1'b0;
    tick();

    // invalid digit 0, no carry into digit 1
    load_value = {C0, 5'b11100};
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("load_invalid", {C0, 5'b11100}, 1'b0, 1'b0);
    tick();
    expect_out("check_set", {C0, 5'b11100}, 1'b0, CHK);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("adv_invalid_d0", {C0, C0}, 1'b0, CHK);
    tick();
    expect_out("check_sticky", {C0, C0}, 1'b0, CHK);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("set0_clears_check", {C0, C0}, 1'b0, 1'b0);
    tick();

    // invalid upper digit reached by carry: becomes 0, no wrap
    load_value = {5'b11111, C9};
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("load_invalid_d1", {5'b11111, C9}, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("carry_into_invalid", {C0, C0}, 1'b0, CHK);
    tick();
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("set0_clears_again", {C0, C0}, 1'b0, 1'b0);
    tick();

    // borrow: 30 - 1 = 29
    load_value = {C3, C0};
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("load_30", {C3, C0}, 1'b0, 1'b0);
    tick();
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("borrow_29", {C2, C9}, 1'b0, 1'b0);
    tick();

    // priority: set0 over load, load over advance
    load_value = {C5, C7};
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("set0_over_load", {C0, C0}, 1'b0, 1'b0);
    tick();
    load_value = {C4, C4};
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_out("load_over_adv", {C4, C4}, 1'b0, 1'b0);
    tick();

    // asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    expect_out("async_reset", {C0, C0}, 1'b0, 1'b0);
    advance = 1'b1; down = 1'b1;
    tick();
    rst_n = 1'b1;
    // advance held through reset release steps on the first clock: 00 - 1
    tick();
    expect_out("down_from_reset", {C9, C9}, 1'b1, 1'b0);
    advance = 1'b0; down = 1'b0;
    tick();
    expect_out("down_wrap_one_clk", {C9, C9}, 1'b0, 1'b0);

    repeat (3) tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
